// File: rtl/backend_pkg.sv
// Shared types and constants for the analog backend power-up controller.
// The serial frame carries a start bit, five gain bits and an even-parity bit.
package backend_pkg;

    typedef enum logic [2:0] {
        S_WAIT_START,
        S_SHIFT,
        S_CHECK,
        S_ERR,
        S_VCO_WAIT,
        S_AMP_WAIT,
        S_RDY_WAIT,
        S_READY
    } state_t;

    localparam int FRAME_LEN = 7;
    localparam int GAIN1_W   = 2;
    localparam int GAIN2_W   = 3;
    localparam int STAGE_W   = FRAME_LEN - 1;

    // True when the data bits together with the parity bit XOR to zero.
    function automatic logic parity_even(input logic [STAGE_W-1:0] bits);
        return ~^bits;
    endfunction

endpackage

// File: rtl/backend_seq_ctrl_if.sv
// Serial config port plus the analog front-end reset/gain pins of the controller.
// The slave side belongs to the controller, the master side to whoever drives it.
interface backend_seq_ctrl_if;

    logic                            i_sclk;
    logic                            i_sdin;
    logic                            i_cfg_req;
    logic                            o_ready;
    logic                            o_resetb1;
    logic [backend_pkg::GAIN1_W-1:0] o_gainA1;
    logic                            o_resetb2;
    logic [backend_pkg::GAIN2_W-1:0] o_gainA2;
    logic                            o_resetbvco;
    logic                            o_cfg_err;

    modport master (
        output i_sclk, i_sdin, i_cfg_req,
        input  o_ready, o_resetb1, o_gainA1, o_resetb2, o_gainA2, o_resetbvco, o_cfg_err
    );

    modport slave (
        input  i_sclk, i_sdin, i_cfg_req,
        output o_ready, o_resetb1, o_gainA1, o_resetb2, o_gainA2, o_resetbvco, o_cfg_err
    );

endinterface

// File: rtl/backend_sclk_sync.sv
// Brings the slow serial clock and data into the system clock domain and emits a
// registered one-cycle pulse per sclk rise together with the matching data sample.
module backend_sclk_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic sdin,
    output logic sclk_rise,
    output logic sdin_s
);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] sdin_sync;
    logic                   sclk_prev;

    // sdin runs through the same number of flops so it stays paired with its rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            sdin_sync <= '0;
            sclk_prev <= 1'b0;
            sclk_rise <= 1'b0;
            sdin_s    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            sdin_sync <= {sdin_sync[SYNC_STAGES-2:0], sdin};
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
            sclk_rise <= sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
            sdin_s    <= sdin_sync[SYNC_STAGES-1];
        end
    end

endmodule

// File: rtl/backend_seq_ctrl.sv
// Power-up controller: captures a parity-checked gain frame from the serial port,
// then releases VCO and amplifier resets in a counter-timed order and raises ready.
module backend_seq_ctrl
    import backend_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int VCO_DLY     = 2,
    parameter int AMP_DLY     = 10,
    parameter int RDY_DLY     = 10,
    parameter int TIMEOUT     = 255,
    parameter int CNT_W       = 8
) (
    input  logic               i_clk,
    input  logic               i_resetbAll,
    backend_seq_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] VCO_LAST  = CNT_W'(VCO_DLY - 1);
    localparam logic [CNT_W-1:0] AMP_LAST  = CNT_W'(AMP_DLY - 1);
    localparam logic [CNT_W-1:0] RDY_LAST  = CNT_W'(RDY_DLY - 1);
    localparam logic [CNT_W-1:0] TO_LIMIT  = CNT_W'(TIMEOUT);
    localparam logic [2:0]       LAST_BIT  = 3'(STAGE_W - 1);

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [2:0]           bit_cnt, bit_cnt_nxt;
    logic [STAGE_W-1:0]   stage, stage_nxt;
    logic                 load_gain;
    logic                 sclk_rise;
    logic                 sdin_s;

    backend_sclk_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (i_clk),
        .rst_n     (i_resetbAll),
        .sclk      (bus.i_sclk),
        .sdin      (bus.i_sdin),
        .sclk_rise (sclk_rise),
        .sdin_s    (sdin_s)
    );

    // One counter serves the mid-frame timeout and all three release delays
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + 1'b1;
        bit_cnt_nxt = bit_cnt;
        stage_nxt   = stage;
        load_gain   = 1'b0;
        case (state)
            S_WAIT_START, S_ERR: begin
                cnt_nxt = '0;
                if (sclk_rise && sdin_s) begin
                    state_nxt   = S_SHIFT;
                    bit_cnt_nxt = '0;
                end
            end
            S_SHIFT: begin
                if (sclk_rise) begin
                    stage_nxt   = {sdin_s, stage[STAGE_W-1:1]};
                    cnt_nxt     = '0;
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == LAST_BIT) begin
                        state_nxt = S_CHECK;
                    end
                end else if (cnt == TO_LIMIT) begin
                    state_nxt = S_ERR;
                    cnt_nxt   = '0;
                end
            end
            S_CHECK: begin
                cnt_nxt = '0;
                if (parity_even(stage)) begin
                    state_nxt = S_VCO_WAIT;
                    load_gain = 1'b1;
                end else begin
                    state_nxt = S_ERR;
                end
            end
            S_VCO_WAIT: begin
                if (cnt == VCO_LAST) begin
                    state_nxt = S_AMP_WAIT;
                    cnt_nxt   = '0;
                end
            end
            S_AMP_WAIT: begin
                if (cnt == AMP_LAST) begin
                    state_nxt = S_RDY_WAIT;
                    cnt_nxt   = '0;
                end
            end
            S_RDY_WAIT: begin
                if (cnt == RDY_LAST) begin
                    state_nxt = S_READY;
                    cnt_nxt   = '0;
                end
            end
            S_READY: begin
                cnt_nxt = '0;
                if (bus.i_cfg_req) begin
                    state_nxt = S_WAIT_START;
                end
            end
            default: begin
                state_nxt = S_WAIT_START;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_resetbAll) begin
        if (!i_resetbAll) begin
            state   <= S_WAIT_START;
            cnt     <= '0;
            bit_cnt <= '0;
            stage   <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_cnt <= bit_cnt_nxt;
            stage   <= stage_nxt;
        end
    end

    // Outputs are decoded from the next state so each one lands on its transition edge
    always_ff @(posedge i_clk or negedge i_resetbAll) begin
        if (!i_resetbAll) begin
            bus.o_gainA1    <= '0;
            bus.o_gainA2    <= '0;
            bus.o_resetbvco <= 1'b0;
            bus.o_resetb1   <= 1'b0;
            bus.o_resetb2   <= 1'b0;
            bus.o_ready     <= 1'b0;
            bus.o_cfg_err   <= 1'b0;
        end else begin
            if (load_gain) begin
                bus.o_gainA1 <= stage[GAIN1_W-1:0];
                bus.o_gainA2 <= stage[GAIN1_W+GAIN2_W-1:GAIN1_W];
            end
            bus.o_resetbvco <= state_nxt inside {S_AMP_WAIT, S_RDY_WAIT, S_READY};
            bus.o_resetb1   <= state_nxt inside {S_RDY_WAIT, S_READY};
            bus.o_resetb2   <= state_nxt inside {S_RDY_WAIT, S_READY};
            bus.o_ready     <= (state_nxt == S_READY);
            bus.o_cfg_err   <= (state_nxt == S_ERR);
        end
    end

endmodule

// File: tb/tb_backend_seq_ctrl.sv
// Bench for backend_seq_ctrl: serial frames are driven bit by bit and the
// resulting gains, error flag and release timing are compared with a frame-level model.
module tb_backend_seq_ctrl;
    import backend_pkg::*;

    localparam int SYNC_STAGES = 2;
    localparam int VCO_DLY     = 2;
    localparam int AMP_DLY     = 10;
    localparam int RDY_DLY     = 10;
    localparam int TIMEOUT     = 255;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    logic [1:0] model_g1;
    logic [2:0] model_g2;
    logic       model_ready;

    backend_seq_ctrl_if bus ();

    backend_seq_ctrl #(
        .SYNC_STAGES (SYNC_STAGES),
        .VCO_DLY     (VCO_DLY),
        .AMP_DLY     (AMP_DLY),
        .RDY_DLY     (RDY_DLY),
        .TIMEOUT     (TIMEOUT),
        .CNT_W       (8)
    ) dut (
        .i_clk       (clk),
        .i_resetbAll (rst_n),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // Frame layout, first bit sent in bit 0: start, gainA1[1:0], gainA2[2:0], parity
    function automatic logic [6:0] make_frame(input logic [2:0] g2, input logic [1:0] g1,
                                              input logic good);
        logic [4:0] data;
        data = {g2, g1};
        return {(^data) ^ ~good, data, 1'b1};
    endfunction

    function automatic logic frame_ok(input logic [6:0] f);
        return f[0] && ((^f[6:1]) == 1'b0);
    endfunction

    task automatic send_bit(input logic b);
        repeat (4) @(negedge clk);
        bus.i_sclk = 1'b0;
        bus.i_sdin = b;
        repeat (4) @(negedge clk);
        bus.i_sclk = 1'b1;
    endtask

    task automatic send_frame(input logic [6:0] f);
        for (int i = 0; i < 7; i++) send_bit(f[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 3) bus.i_sclk = 1'b0;
        end
    endtask

    // Observes one accepted frame from its last sclk rise through ready.
    task automatic test_power_sequence(input string name, input logic [1:0] g1,
                                       input logic [2:0] g2);
        int   vco_at, amp_at, b2_at, rdy_at, gain_at;
        logic changed;
        vco_at = -1; amp_at = -1; b2_at = -1; rdy_at = -1; gain_at = -1;
        changed = (g1 != model_g1) || (g2 != model_g2);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (i == 3) bus.i_sclk = 1'b0;
            if (gain_at < 0 && bus.o_gainA1 == g1 && bus.o_gainA2 == g2) gain_at = i;
            if (vco_at < 0 && bus.o_resetbvco) vco_at = i;
            if (amp_at < 0 && bus.o_resetb1) amp_at = i;
            if (b2_at < 0 && bus.o_resetb2) b2_at = i;
            if (rdy_at < 0 && bus.o_ready) rdy_at = i;
        end
        tests++;
        if (vco_at < 0) begin
            fails++;
            $display("FAIL %s vco_release: never seen within 60 cycles, required", name);
        end
        if (changed) begin
            tests++;
            if (gain_at !== SYNC_STAGES + 2) begin
                fails++;
                $display("FAIL %s gain_latency: got %0d want %0d", name, gain_at, SYNC_STAGES + 2);
            end
            tests++;
            if (vco_at - gain_at !== VCO_DLY) begin
                fails++;
                $display("FAIL %s gain_to_vco: got %0d want %0d", name, vco_at - gain_at, VCO_DLY);
            end
        end
        tests++;
        if (amp_at - vco_at !== AMP_DLY) begin
            fails++;
            $display("FAIL %s vco_to_amp: got %0d want %0d", name, amp_at - vco_at, AMP_DLY);
        end
        tests++;
        if (b2_at !== amp_at) begin
            fails++;
            $display("FAIL %s resetb2_align: got %0d want %0d", name, b2_at, amp_at);
        end
        tests++;
        if (rdy_at - amp_at !== RDY_DLY) begin
            fails++;
            $display("FAIL %s amp_to_ready: got %0d want %0d", name, rdy_at - amp_at, RDY_DLY);
        end
        tests++;
        if ({bus.o_gainA1, bus.o_gainA2, bus.o_cfg_err, bus.o_ready} !== {g1, g2, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL %s final_state: got g1=%b g2=%b err=%b rdy=%b want g1=%b g2=%b err=0 rdy=1",
                     name, bus.o_gainA1, bus.o_gainA2, bus.o_cfg_err, bus.o_ready, g1, g2);
        end
        model_g1 = g1;
        model_g2 = g2;
        model_ready = 1'b1;
    endtask

    task automatic test_rejected(input string name);
        idle(20);
        tests++;
        if ({bus.o_cfg_err, bus.o_ready, bus.o_resetbvco, bus.o_resetb1, bus.o_resetb2,
             bus.o_gainA1, bus.o_gainA2} !== {1'b1, 4'b0000, model_g1, model_g2}) begin
            fails++;
            $display("FAIL %s reject: got err=%b rdy=%b vco=%b b1=%b b2=%b g1=%b g2=%b want err=1 rest 0 g1=%b g2=%b",
                     name, bus.o_cfg_err, bus.o_ready, bus.o_resetbvco, bus.o_resetb1, bus.o_resetb2,
                     bus.o_gainA1, bus.o_gainA2, model_g1, model_g2);
        end
        model_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({bus.o_ready, bus.o_resetb1, bus.o_resetb2, bus.o_resetbvco, bus.o_cfg_err,
             bus.o_gainA1, bus.o_gainA2} !== 10'b0) begin
            fails++;
            $display("FAIL reset_outputs: got rdy=%b b1=%b b2=%b vco=%b err=%b g1=%b g2=%b want all 0",
                     bus.o_ready, bus.o_resetb1, bus.o_resetb2, bus.o_resetbvco, bus.o_cfg_err,
                     bus.o_gainA1, bus.o_gainA2);
        end
        model_g1 = '0;
        model_g2 = '0;
        model_ready = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_bad_parity();
        send_frame(make_frame(3'b011, 2'b01, 1'b0));
        test_rejected("bad_parity");
        send_frame(make_frame(3'b011, 2'b01, 1'b1));
        test_power_sequence("valid_after_err", 2'b01, 3'b011);
    endtask

    task automatic test_cfg_req(input string name);
        tests++;
        if (bus.o_ready !== model_ready) begin
            fails++;
            $display("FAIL %s ready_before_req: got %b want %b", name, bus.o_ready, model_ready);
        end
        @(negedge clk);
        bus.i_cfg_req = 1'b1;
        @(negedge clk);
        bus.i_cfg_req = 1'b0;
        if (model_ready) begin
            tests++;
            if ({bus.o_ready, bus.o_resetb1, bus.o_resetb2, bus.o_resetbvco,
                 bus.o_gainA1, bus.o_gainA2} !== {4'b0000, model_g1, model_g2}) begin
                fails++;
                $display("FAIL %s after_req: got rdy=%b b1=%b b2=%b vco=%b g1=%b g2=%b want 0000 g1=%b g2=%b",
                         name, bus.o_ready, bus.o_resetb1, bus.o_resetb2, bus.o_resetbvco,
                         bus.o_gainA1, bus.o_gainA2, model_g1, model_g2);
            end
            model_ready = 1'b0;
        end
    endtask

    task automatic test_reconfig();
        test_cfg_req("reconfig");
        send_frame(make_frame(3'b100, 2'b10, 1'b1));
        test_power_sequence("reconfig_seq", 2'b10, 3'b100);
    endtask

    task automatic test_leading_zeros();
        test_cfg_req("lead_zero");
        repeat (3) send_bit(1'b0);
        send_frame(make_frame(3'b110, 2'b11, 1'b1));
        test_power_sequence("lead_zero_seq", 2'b11, 3'b110);
    endtask

    task automatic test_timeout();
        test_cfg_req("timeout");
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        idle(TIMEOUT + 40);
        tests++;
        if ({bus.o_cfg_err, bus.o_ready, bus.o_resetbvco} !== 3'b100) begin
            fails++;
            $display("FAIL timeout_err: got err=%b rdy=%b vco=%b want err=1 rdy=0 vco=0",
                     bus.o_cfg_err, bus.o_ready, bus.o_resetbvco);
        end
        model_ready = 1'b0;
        send_frame(make_frame(3'b101, 2'b00, 1'b1));
        test_power_sequence("after_timeout", 2'b00, 3'b101);
    endtask

    task automatic test_random();
        logic [6:0] f;
        logic [1:0] g1;
        logic [2:0] g2;
        for (int n = 0; n < 6; n++) begin
            g1 = 2'($urandom_range(0, 3));
            g2 = 3'($urandom_range(0, 7));
            f  = make_frame(g2, g1, ($urandom_range(0, 3) != 0));
            test_cfg_req("random_req");
            send_frame(f);
            if (frame_ok(f)) test_power_sequence("random_seq", g1, g2);
            else test_rejected("random_bad");
        end
    endtask

    task automatic test_reset_midway();
        int seen;
        seen = -1;
        test_cfg_req("midreset");
        send_frame(make_frame(3'b010, 2'b01, 1'b1));
        for (int i = 0; i < 40 && seen < 0; i++) begin
            @(negedge clk);
            if (i == 3) bus.i_sclk = 1'b0;
            if (bus.o_resetbvco) seen = i;
        end
        bus.i_sclk = 1'b0;
        tests++;
        if (seen < 0) begin
            fails++;
            $display("FAIL midreset_vco: never released within 40 cycles");
        end
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({bus.o_ready, bus.o_resetb1, bus.o_resetb2, bus.o_resetbvco, bus.o_cfg_err,
             bus.o_gainA1, bus.o_gainA2} !== 10'b0) begin
            fails++;
            $display("FAIL midreset_async: got rdy=%b b1=%b b2=%b vco=%b err=%b g1=%b g2=%b want all 0",
                     bus.o_ready, bus.o_resetb1, bus.o_resetb2, bus.o_resetbvco, bus.o_cfg_err,
                     bus.o_gainA1, bus.o_gainA2);
        end
        model_g1 = '0;
        model_g2 = '0;
        model_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_bit(1'b0);
        idle(30);
        tests++;
        if ({bus.o_ready, bus.o_resetbvco, bus.o_resetb1, bus.o_cfg_err} !== 4'b0000) begin
            fails++;
            $display("FAIL midreset_idle: got rdy=%b vco=%b b1=%b err=%b want 0000",
                     bus.o_ready, bus.o_resetbvco, bus.o_resetb1, bus.o_cfg_err);
        end
        send_frame(make_frame(3'b111, 2'b10, 1'b1));
        test_power_sequence("after_midreset", 2'b10, 3'b111);
    endtask

    initial begin
        bus.i_sclk    = 1'b0;
        bus.i_sdin    = 1'b0;
        bus.i_cfg_req = 1'b0;
        model_g1      = '0;
        model_g2      = '0;
        model_ready   = 1'b0;
        test_reset();
        test_bad_parity();
        test_reconfig();
        test_leading_zeros();
        test_timeout();
        test_random();
        test_reset_midway();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
